// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload, masked IRQ.
// Latency: register writes land on the WE edge, reads are combinational; IRQ rises PRESET+3 edges after enable.
// Backpressure: none; the bridge may write every cycle and bus writes take priority over FSM updates.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        ctrl_wr;
    logic        preset_wr;
    logic        enable;
    logic        auto_reload;
    logic        load_cnt;
    logic        dec_cnt;
    logic        set_irq;
    logic        clr_irq;
    logic        clr_en;
    logic        unused_addr;

    assign ctrl_wr     = WE && (Addr[3:2] == 2'd0);
    assign preset_wr   = WE && (Addr[3:2] == 2'd1);
    assign enable      = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    always_comb begin
        state_nxt = state;
        load_cnt  = 1'b0;
        dec_cnt   = 1'b0;
        set_irq   = 1'b0;
        clr_irq   = 1'b0;
        clr_en    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = LOAD;
            end
            LOAD: begin
                load_cnt  = 1'b1;
                state_nxt = CNT;
            end
            CNT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (count == 32'd0) begin
                    set_irq   = 1'b1;
                    state_nxt = INT;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            INT: begin
                // Modes 10/11 fall into the one-shot branch.
                if (auto_reload) begin
                    clr_irq   = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    clr_en    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state <= state_nxt;

            if (load_cnt)     count <= preset;
            else if (dec_cnt) count <= count - 32'd1;

            // A bus write to CTRL overrides the one-shot enable clear.
            if (ctrl_wr)     ctrl    <= Din[3:0];
            else if (clr_en) ctrl[0] <= 1'b0;

            if (preset_wr) preset <= Din;

            // Any CTRL write acknowledges, even on the edge the flag would rise.
            if (ctrl_wr)      irq_flag <= 1'b0;
            else if (set_irq) irq_flag <= 1'b1;
            else if (clr_irq) irq_flag <= 1'b0;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            2'd0:    Dout = {28'd0, ctrl};
            2'd1:    Dout = preset;
            2'd2:    Dout = count;
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag & ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register map, one-shot, auto-reload, masking, mid-count disable, reset.
module tb_timer_counter;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int tests;
    int fails;

    timer_counter dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        chk(tag, Dout, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        chk(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = 32'd0;
        Din   = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state and register map
        rd_chk("rst_ctrl", A_CTRL, 32'd0);
        rd_chk("rst_preset", A_PRESET, 32'd0);
        rd_chk("rst_count", A_COUNT, 32'd0);
        rd_chk("rst_rsvd", A_RSVD, 32'd0);
        irq_chk("rst_irq", 1'b0);
        bus_write(A_COUNT, 32'h0000_1234);
        rd_chk("count_ro", A_COUNT, 32'd0);
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        rd_chk("rsvd_ro", A_RSVD, 32'd0);
        bus_write(A_CTRL, 32'hFFFF_FFF0);
        rd_chk("ctrl_upper_zero", A_CTRL, 32'd0);

        // One-shot, PRESET=5, IM=1
        bus_write(A_PRESET, 32'd5);
        rd_chk("preset_rd", A_PRESET, 32'd5);
        bus_write(A_CTRL, 32'h9);
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            rd_chk($sformatf("os_count%0d", i), A_COUNT, 32'(5 - i));
            irq_chk($sformatf("os_irq_low%0d", i), 1'b0);
            tick();
        end
        irq_chk("os_irq_rise", 1'b1);
        tick();
        rd_chk("os_ctrl_en_clr", A_CTRL, 32'h8);
        irq_chk("os_irq_sticky", 1'b1);
        tick();
        tick();
        irq_chk("os_irq_sticky2", 1'b1);
        bus_write(A_CTRL, 32'h0);
        irq_chk("os_irq_ack", 1'b0);

        // Auto-reload, PRESET=3: period 6
        bus_write(A_PRESET, 32'd3);
        bus_write(A_CTRL, 32'hB);
        for (int k = 1; k <= 24; k++) begin
            tick();
            irq_chk($sformatf("ar_irq%0d", k), (k % 6) == 0);
        end
        tick();
        irq_chk("ar_load", 1'b0);
        tick();
        rd_chk("ar_cnt_start", A_COUNT, 32'd3);
        bus_write(A_PRESET, 32'd1);
        rd_chk("ar_cnt_unchanged", A_COUNT, 32'd2);
        for (int k = 28; k <= 38; k++) begin
            tick();
            irq_chk($sformatf("ar2_irq%0d", k), (k == 30) || (k == 34) || (k == 38));
            if (k == 32) rd_chk("ar2_reload", A_COUNT, 32'd1);
        end
        bus_write(A_CTRL, 32'h0);
        irq_chk("ar_stop_irq", 1'b0);
        tick();
        tick();
        tick();
        irq_chk("ar_idle_irq", 1'b0);

        // Masked one-shot, PRESET=10
        bus_write(A_PRESET, 32'd10);
        bus_write(A_CTRL, 32'h1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            irq_chk($sformatf("mask_irq%0d", k), 1'b0);
        end
        rd_chk("mask_ctrl", A_CTRL, 32'h0);
        rd_chk("mask_count", A_COUNT, 32'd0);
        bus_write(A_PRESET, 32'd7);
        irq_chk("mask_preset_wr", 1'b0);
        bus_write(A_CTRL, 32'h8);
        irq_chk("mask_im_set", 1'b0);
        tick();
        irq_chk("mask_im_set2", 1'b0);

        // Disable mid-count, then restart
        bus_write(A_PRESET, 32'd100);
        bus_write(A_CTRL, 32'h9);
        tick();
        tick();
        rd_chk("dis_load", A_COUNT, 32'd100);
        repeat (60) tick();
        rd_chk("dis_at40", A_COUNT, 32'd40);
        bus_write(A_CTRL, 32'h8);
        rd_chk("dis_last_dec", A_COUNT, 32'd39);
        tick();
        tick();
        tick();
        rd_chk("dis_frozen", A_COUNT, 32'd39);
        rd_chk("dis_ctrl", A_CTRL, 32'h8);
        irq_chk("dis_irq", 1'b0);
        bus_write(A_CTRL, 32'h9);
        rd_chk("re_hold", A_COUNT, 32'd39);
        tick();
        tick();
        rd_chk("re_reload", A_COUNT, 32'd100);

        // Synchronous reset mid-count, with a coincident CTRL write
        repeat (93) tick();
        rd_chk("pre_rst_count", A_COUNT, 32'd7);
        reset = 1'b1;
        Addr  = A_CTRL;
        Din   = 32'hF;
        WE    = 1'b1;
        tick();
        reset = 1'b0;
        WE    = 1'b0;
        rd_chk("mr_ctrl", A_CTRL, 32'd0);
        rd_chk("mr_preset", A_PRESET, 32'd0);
        rd_chk("mr_count", A_COUNT, 32'd0);
        irq_chk("mr_irq", 1'b0);
        bus_write(A_PRESET, 32'd2);
        tick();
        tick();
        rd_chk("mr_idle_count", A_COUNT, 32'd0);
        rd_chk("mr_idle_ctrl", A_CTRL, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
